ghost_nav_ctrl: RTL

//  Parametrised ghost navigation controller: position register, step-rate divider, turn FSM.

---
 rtl/ghost_nav_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ghost_nav_ctrl.sv
// Ghost navigation: position register, step-rate divider, LFSR and turn FSM (MOVE/TURN/SETTLE).
// Optional frightened behaviour (flee + half speed) is built when GHOST_FRIGHT_EN is defined.
module ghost_nav_ctrl #(
    parameter int          X_W        = 10,
    parameter int          Y_W        = 9,
    parameter int          X_START    = 200,
    parameter int          Y_START    = 146,
    parameter int          X_MIN      = 0,
    parameter int          X_MAX      = 639,
    parameter int          Y_MIN      = 0,
    parameter int          Y_MAX      = 479,
    parameter int          STEP_DIV   = 131072,
    parameter int          MODE_STEPS = 256,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           blocked,
    input  logic [X_W-1:0] pac_x,
    input  logic [Y_W-1:0] pac_y,
    input  logic           fright,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic [1:0]     direction,
    output logic [1:0]     next_dir,
    output logic           mode,
    output logic           step_pulse
);
    localparam int          DIV_W  = $clog2(STEP_DIV);
    localparam int          MODE_W = $clog2(MODE_STEPS + 1);
    localparam int          AW     = (X_W > Y_W) ? X_W + 1 : Y_W + 1;
    localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {S_MOVE, S_TURN, S_SETTLE} state_t;

    state_t            state_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [1:0]        dir_q, nd_q;
    logic              mode_q, mode_d;
    logic              step_q, step_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [MODE_W-1:0] mcnt_q, mcnt_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic              tick, move_tick, mode_tick, flee;
    logic              edge_hit, stop;
    logic [1:0]        rnd, rule_dir, chase_dir, c0, c1, cand;
    logic              rule_valid;
    logic signed [X_W:0] dx;
    logic signed [Y_W:0] dy;
    logic [X_W:0]      ax;
    logic [Y_W:0]      ay;

    assign tick = step_q & enable;

`ifdef GHOST_FRIGHT_EN
    logic half_q;

    // Frightened ghosts move on every second tick and hold their mode phase.
    always_ff @(posedge clk) begin
        if (rst || !fright) half_q <= 1'b0;
        else if (tick)      half_q <= ~half_q;
    end

    assign flee      = fright;
    assign move_tick = tick & (~fright | half_q);
    assign mode_tick = tick & ~fright;
`else
    logic unused_fright;
    assign unused_fright = fright;
    assign flee      = 1'b0;
    assign move_tick = tick;
    assign mode_tick = tick;
`endif

    assign rnd = lfsr_q[1:0];

    always_comb begin
        div_d  = (div_q == DIV_W'(STEP_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        step_d = (div_q == DIV_W'(STEP_DIV - 1));
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        mcnt_d = mcnt_q;
        mode_d = mode_q;
        if (mode_tick) begin
            if (mcnt_q == MODE_W'(MODE_STEPS - 1)) begin
                mcnt_d = '0;
                mode_d = ~mode_q;
            end else begin
                mcnt_d = mcnt_q + MODE_W'(1);
            end
        end
    end

    always_comb begin
        edge_hit = ((dir_q == 2'b00) && (y_q == Y_W'(Y_MIN))) ||
                   ((dir_q == 2'b01) && (y_q == Y_W'(Y_MAX))) ||
                   ((dir_q == 2'b10) && (x_q == X_W'(X_MIN))) ||
                   ((dir_q == 2'b11) && (x_q == X_W'(X_MAX)));
        stop = blocked | edge_hit;
    end

    // Chase: dominant axis toward the player, ties go to x; no offset falls back to rnd.
    always_comb begin
        dx = $signed({1'b0, pac_x}) - $signed({1'b0, x_q});
        dy = $signed({1'b0, pac_y}) - $signed({1'b0, y_q});
        ax = dx[X_W] ? (~dx + 1'b1) : dx;
        ay = dy[Y_W] ? (~dy + 1'b1) : dy;
        rule_dir   = 2'b00;
        rule_valid = 1'b0;
        if ((AW'(ax) >= AW'(ay)) && (dx != '0)) begin
            rule_dir   = dx[X_W] ? 2'b10 : 2'b11;
            rule_valid = 1'b1;
        end else if (dy != '0) begin
            rule_dir   = dy[Y_W] ? 2'b00 : 2'b01;
            rule_valid = 1'b1;
        end
        chase_dir = rule_valid ? (rule_dir ^ {1'b0, flee}) : rnd;
        c0   = mode_q ? chase_dir : rnd;
        c1   = (c0 == dir_q) ? rnd : c0;
        cand = (c1 == dir_q) ? (dir_q ^ 2'b01) : c1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_MOVE;
            x_q     <= X_W'(X_START);
            y_q     <= Y_W'(Y_START);
            dir_q   <= 2'b00;
            nd_q    <= 2'b00;
            mode_q  <= 1'b0;
            step_q  <= 1'b0;
            div_q   <= '0;
            mcnt_q  <= '0;
            lfsr_q  <= SEED;
        end else begin
            div_q  <= div_d;
            step_q <= step_d;
            lfsr_q <= lfsr_d;
            mcnt_q <= mcnt_d;
            mode_q <= mode_d;
            case (state_q)
                S_MOVE: begin
                    if (move_tick) begin
                        if (stop) begin
                            state_q <= S_TURN;
                        end else begin
                            case (dir_q)
                                2'b00:   y_q <= y_q - Y_W'(1);
                                2'b01:   y_q <= y_q + Y_W'(1);
                                2'b10:   x_q <= x_q - X_W'(1);
                                default: x_q <= x_q + X_W'(1);
                            endcase
                        end
                    end
                end
                S_TURN: begin
                    dir_q   <= cand;
                    nd_q    <= cand;
                    state_q <= S_SETTLE;
                end
                S_SETTLE: state_q <= S_MOVE;
                default:  state_q <= S_MOVE;
            endcase
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign direction  = dir_q;
    assign next_dir   = nd_q;
    assign mode       = mode_q;
    assign step_pulse = step_q;
endmodule
